uart_alu_ctrl: RTL and testbench

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_pkg.sv | 34 +++
 rtl/pulse_edge_det.sv | 22 ++
 rtl/uart_alu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU: widths, opcodes and controller states.
// Used by uart_alu_ctrl and by the ALU itself.
package uart_alu_pkg;

   localparam int SIZEDATA_DEF = 8;
   localparam int SIZEOP_DEF   = 6;

   localparam logic [SIZEOP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [SIZEOP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [SIZEOP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [SIZEOP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [SIZEOP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [SIZEOP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [SIZEOP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [SIZEOP_DEF-1:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   function automatic logic is_supported_op(input logic [SIZEOP_DEF-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_supported_op = 1'b1;
         default:                        is_supported_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Rising-edge detector: registers the previous level and emits a registered
// one-cycle pulse when the input goes from low to high.
module pulse_edge_det (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         prev <= level;
         rise <= level & ~prev;
      end
   end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame controller between a UART and an ALU: collects operand A, operand B and
// an opcode byte, sends back the ALU result. Optional inter-byte timeout: UART_ALU_CTRL_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for operand A byte
// ST_WAIT_B  | operand A latched, waiting for operand B byte
// ST_WAIT_OP | operands latched, waiting for opcode byte
// ST_COMPUTE | one cycle for the ALU to settle, result registered
// ST_SEND    | o_tx_signal high for this single cycle
// ST_WAIT_TX | waiting for the transmitter to finish the frame
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int SIZEDATA       = SIZEDATA_DEF,
   parameter int SIZEOP         = SIZEOP_DEF,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_rx_done,
   input  logic [SIZEDATA-1:0] i_rx_data,
   input  logic                i_tx_done,
   input  logic [SIZEDATA-1:0] i_alu_result,
   output logic [SIZEDATA-1:0] o_op_a,
   output logic [SIZEDATA-1:0] o_op_b,
   output logic [SIZEOP-1:0]   o_opcode,
   output logic                o_tx_signal,
   output logic [SIZEDATA-1:0] o_tx_result,
   output logic                o_op_err,
   output logic                o_busy
);

   state_t              state;
   logic                rx_rise;
   logic                tx_rise;
   logic [SIZEDATA-1:0] op_a;
   logic [SIZEDATA-1:0] op_b;
   logic [SIZEOP-1:0]   opcode;
   logic [SIZEDATA-1:0] tx_result;
   logic                tx_signal;
   logic                op_err;
   logic                busy;
   logic [SIZEOP-1:0]   op_in;

   assign op_in = i_rx_data[SIZEOP-1:0];

   pulse_edge_det u_rx_edge (
      .clock (i_clock),
      .reset (i_reset),
      .level (i_rx_done),
      .rise  (rx_rise)
   );

   pulse_edge_det u_tx_edge (
      .clock (i_clock),
      .reset (i_reset),
      .level (i_tx_done),
      .rise  (tx_rise)
   );

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_expired;

   assign to_expired = (to_cnt == '0);

   // Reloaded on every accepted operand byte, runs down while a frame is half-received.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         to_cnt <= '0;
      end else if (rx_rise && (state == ST_IDLE || state == ST_WAIT_B)) begin
         to_cnt <= TO_LOAD;
      end else if ((state == ST_WAIT_B || state == ST_WAIT_OP) && !to_expired) begin
         to_cnt <= to_cnt - 1'b1;
      end
   end
`else
   // TIMEOUT_CYCLES has no function in this build; the block keeps it referenced.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= ST_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         opcode    <= '0;
         tx_result <= '0;
         tx_signal <= 1'b0;
         op_err    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tx_signal <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (rx_rise) begin
                  op_a   <= i_rx_data;
                  op_err <= 1'b0;
                  busy   <= 1'b1;
                  state  <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (rx_rise) begin
                  op_b  <= i_rx_data;
                  state <= ST_WAIT_OP;
               end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
               else if (to_expired) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
`endif
            end
            ST_WAIT_OP: begin
               if (rx_rise) begin
                  opcode <= op_in;
                  op_err <= ~is_supported_op(SIZEOP_DEF'(op_in));
                  state  <= ST_COMPUTE;
               end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
               else if (to_expired) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
`endif
            end
            ST_COMPUTE: begin
               tx_result <= i_alu_result;
               tx_signal <= 1'b1;
               state     <= ST_SEND;
            end
            ST_SEND: begin
               state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (tx_rise) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_op_a      = op_a;
   assign o_op_b      = op_b;
   assign o_opcode    = opcode;
   assign o_tx_signal = tx_signal;
   assign o_tx_result = tx_result;
   assign o_op_err    = op_err;
   assign o_busy      = busy;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small behavioural ALU on the operand/opcode outputs.
// Build with UART_ALU_CTRL_TIMEOUT_EN defined to also exercise the inter-byte timeout.
module tb_uart_alu_ctrl;

   logic       clk;
   logic       rst_n;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_done;
   logic [7:0] alu_result;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [5:0] opcode;
   logic       tx_signal;
   logic [7:0] tx_result;
   logic       op_err;
   logic       busy;

   int checks;
   int errors;
   int tx_count;

   uart_alu_ctrl #(
      .SIZEDATA       (8),
      .SIZEOP         (6),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_rx_done    (rx_done),
      .i_rx_data    (rx_data),
      .i_tx_done    (tx_done),
      .i_alu_result (alu_result),
      .o_op_a       (op_a),
      .o_op_b       (op_b),
      .o_opcode     (opcode),
      .o_tx_signal  (tx_signal),
      .o_tx_result  (tx_result),
      .o_op_err     (op_err),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unsupported opcodes produce a recognisable constant so a sent result is visible.
   always_comb begin
      case (opcode)
         6'b100000: alu_result = op_a + op_b;
         6'b100010: alu_result = op_a - op_b;
         6'b100100: alu_result = op_a & op_b;
         6'b100101: alu_result = op_a | op_b;
         6'b100110: alu_result = op_a ^ op_b;
         6'b100111: alu_result = ~(op_a | op_b);
         6'b000011: alu_result = 8'($signed(op_a) >>> op_b[2:0]);
         6'b000010: alu_result = op_a >> op_b[2:0];
         default:   alu_result = 8'hA5;
      endcase
   end

   always @(negedge clk) if (tx_signal) tx_count++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rx_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_opcode_check(input logic [7:0] op, input logic [7:0] exp_res,
                                    input logic exp_err, input string name);
      int first;
      int hits;
      first = 0;
      hits  = 0;
      @(negedge clk);
      rx_data = op;
      rx_done = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (tx_signal) begin
            hits++;
            if (first == 0) first = k;
         end
         if (k == 2) begin
            @(negedge clk);
            rx_done = 1'b0;
         end
      end
      checks++;
      if (first !== 3) begin
         errors++;
         $display("FAIL %s_latency: tx_signal after %0d clocks, expected 3", name, first);
      end
      checks++;
      if (hits !== 1) begin
         errors++;
         $display("FAIL %s_pulse_width: tx_signal high %0d cycles, expected 1", name, hits);
      end
      checks++;
      if (tx_result !== exp_res) begin
         errors++;
         $display("FAIL %s_result: got %h expected %h", name, tx_result, exp_res);
      end
      checks++;
      if (op_err !== exp_err) begin
         errors++;
         $display("FAIL %s_op_err: got %b expected %b", name, op_err, exp_err);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy_wait_tx: got %b expected 1", name, busy);
      end
   endtask

   task automatic finish_tx(input string name);
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_after_tx: busy got %b expected 0", name, busy);
      end
   endtask

   task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp_res, input logic exp_err, input string name);
      send_byte(a);
      send_byte(b);
      send_opcode_check(op, exp_res, exp_err, name);
      finish_tx(name);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      tx_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({op_a, op_b, tx_result} !== 24'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h expected 00 00 00", op_a, op_b, tx_result);
      end
      checks++;
      if (opcode !== 6'h00) begin
         errors++;
         $display("FAIL reset_opcode: got %h expected 00", opcode);
      end
      checks++;
      if ({tx_signal, op_err, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {tx_signal, op_err, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_alu_ops();
      do_frame(8'h04, 8'h08, 8'h20, 8'h0C, 1'b0, "add");
      checks++;
      if (opcode !== 6'h20 || op_a !== 8'h04 || op_b !== 8'h08) begin
         errors++;
         $display("FAIL add_operands_held: got %h %h %h expected 04 08 20", op_a, op_b, opcode);
      end
      do_frame(8'h04, 8'h08, 8'h22, 8'hFC, 1'b0, "sub");
      do_frame(8'h04, 8'h08, 8'h27, 8'hF3, 1'b0, "nor");
   endtask

   task automatic test_op_err();
      do_frame(8'h04, 8'h08, 8'h3F, 8'hA5, 1'b1, "bad_op");
      send_byte(8'h01);
      checks++;
      if (op_err !== 1'b0) begin
         errors++;
         $display("FAIL op_err_clear: got %b expected 0", op_err);
      end
      checks++;
      if (op_a !== 8'h01) begin
         errors++;
         $display("FAIL op_err_next_a: got %h expected 01", op_a);
      end
      send_byte(8'h02);
      send_opcode_check(8'h20, 8'h03, 1'b0, "after_bad");
      finish_tx("after_bad");
   endtask

   task automatic test_wait_tx_ignore();
      send_byte(8'h04);
      send_byte(8'h08);
      send_opcode_check(8'h20, 8'h0C, 1'b0, "wait_tx");
      send_byte(8'h55);
      checks++;
      if (busy !== 1'b1 || op_a !== 8'h04 || op_b !== 8'h08) begin
         errors++;
         $display("FAIL wait_tx_ignore: got busy=%b a=%h b=%h expected 1 04 08", busy, op_a, op_b);
      end
      finish_tx("wait_tx");
      do_frame(8'h01, 8'h02, 8'h20, 8'h03, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid();
      int tx_before;
      send_byte(8'h04);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_busy_before: got %b expected 1", busy);
      end
      tx_before = tx_count;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || op_a !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_clear: got busy=%b a=%h expected 0 00", busy, op_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (tx_count !== tx_before) begin
         errors++;
         $display("FAIL mid_reset_spurious_tx: got %0d pulses expected %0d", tx_count, tx_before);
      end
      do_frame(8'h02, 8'h03, 8'h20, 8'h05, 1'b0, "after_reset");
   endtask

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      send_byte(8'h04);
      repeat (90) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: busy got %b expected 1", busy);
      end
      repeat (11) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: busy got %b expected 0", busy);
      end
      do_frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, "after_timeout");
   endtask
`endif

   initial begin
      checks   = 0;
      errors   = 0;
      tx_count = 0;
      test_reset();
      test_alu_ops();
      test_op_err();
      test_wait_tx_ignore();
      test_reset_mid();
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
